// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Produces one quotient bit per clock. The result is {remainder, quotient},
// and ready stays high until the requester drops start.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FREE   | idle; waits for start, captures operand magnitudes and signs
// S_BYZERO | divisor was zero; one edge, then done with a zero result
// S_ON     | iterating; one restoring step per edge, then sign fix-up
// S_END    | result valid; waits for start to drop (or annul)
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  start,
    input  logic                  annul,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   dvd_q;      // dividend magnitude; quotient bits shift in at the LSB
    logic [DATA_W-1:0]   dvs_q;      // divisor magnitude
    logic [DATA_W-1:0]   rem_q;      // partial remainder
    logic                sgn_q;
    logic                neg_a_q;
    logic                neg_b_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     step_upper;
    logic [DATA_W:0]     step_diff;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign a_neg = signed_div & opdata1[DATA_W-1];
    assign b_neg = signed_div & opdata2[DATA_W-1];
    assign a_mag = a_neg ? (~opdata1 + 1'b1) : opdata1;
    assign b_mag = b_neg ? (~opdata2 + 1'b1) : opdata2;

    // Restoring step: the borrow out of the DATA_W+1 bit trial subtract is the sign test.
    // The partial remainder stays below the divisor, so the trial never overflows.
    always_comb begin
        step_upper = {rem_q, dvd_q[DATA_W-1]};
        step_diff  = step_upper - {1'b0, dvs_q};
    end

    // Truncating division: quotient sign is the XOR of operand signs, remainder follows the dividend.
    always_comb begin
        quo_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? (~dvd_q + 1'b1) : dvd_q;
        rem_fix = (sgn_q && neg_a_q) ? (~rem_q + 1'b1) : rem_q;
    end

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_q <= 1'b0;
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q <= S_ON;
                            cnt_q   <= '0;
                            dvd_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            sgn_q   <= signed_div;
                            neg_a_q <= a_neg;
                            neg_b_q <= b_neg;
                        end
                    end
                end
                S_BYZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    state_q  <= (annul || !start) ? S_FREE : S_END;
                end
                S_ON: begin
                    if (annul || !start) begin
                        state_q  <= S_FREE;
                        cnt_q    <= '0;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else if (cnt_q != CNT_W'(DATA_W)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!step_diff[DATA_W]) begin
                            rem_q <= step_diff[DATA_W-1:0];
                            dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_q <= step_upper[DATA_W-1:0];
                            dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        state_q  <= S_END;
                        cnt_q    <= '0;
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                    end
                end
                S_END: begin
                    if (annul || !start) begin
                        state_q  <= S_FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_FREE;
                    result_q <= '0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
